// File: rtl/mul_exec_unit.sv
// Pipelined signed multiply execution unit with a result broadcast and RS back-pressure.
// Optional feature: define MUL_EXU_MULH_EN to select the upper product half per op via op_hi.
module mul_exec_unit #(
   parameter int DATA_W    = 32,
   parameter int PRF_TAG_W = 5,
   parameter int ROB_TAG_W = 4,
   parameter int LAT       = 3   // legal range 2..6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stop,
   input  logic                 valid_issue,
   input  logic [PRF_TAG_W-1:0] tag_PRF_issue,
   input  logic [ROB_TAG_W-1:0] tag_ROB_issue,
   input  logic [DATA_W-1:0]    src_a,
   input  logic [DATA_W-1:0]    src_b,
   input  logic                 op_hi,
   input  logic                 wb_ready,
   output logic                 freeze_back,
   output logic                 valid_Result_mul,
   output logic [PRF_TAG_W-1:0] tag_PRF_mul,
   output logic [ROB_TAG_W-1:0] tag_ROB_mul,
   output logic [DATA_W-1:0]    result_mul
);

   localparam int PROD_W = 2 * DATA_W;

   typedef struct packed {
      logic [PRF_TAG_W-1:0] tag_prf;
      logic [ROB_TAG_W-1:0] tag_rob;
`ifdef MUL_EXU_MULH_EN
      logic                 hi;
`endif
      logic [DATA_W-1:0]    a;
      logic [DATA_W-1:0]    b;
   } op_t;

   typedef struct packed {
      logic [PRF_TAG_W-1:0] tag_prf;
      logic [ROB_TAG_W-1:0] tag_rob;
`ifdef MUL_EXU_MULH_EN
      logic                 hi;
`endif
      logic [PROD_W-1:0]    product;
   } stage_t;

   logic [LAT-1:0] stage_v;
   stage_t         stage_q [LAT];
   logic           hold_v;
   op_t            hold_q;

   op_t                      issue_op;
   op_t                      s0_op;
   logic                     s0_v;
   logic                     stall;
   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] b_ext;
   logic signed [PROD_W-1:0] s0_product;

   assign stall       = stage_v[LAT-1] & ~wb_ready;
   assign freeze_back = stall | hold_v;

   always_comb begin
      issue_op.tag_prf = tag_PRF_issue;
      issue_op.tag_rob = tag_ROB_issue;
`ifdef MUL_EXU_MULH_EN
      issue_op.hi      = op_hi;
`endif
      issue_op.a       = src_a;
      issue_op.b       = src_b;
   end

   // The parked op is older than anything on the issue port, so it always wins s0.
   assign s0_op = hold_v ? hold_q : issue_op;
   assign s0_v  = hold_v | valid_issue;

   assign a_ext      = PROD_W'($signed(s0_op.a));
   assign b_ext      = PROD_W'($signed(s0_op.b));
   assign s0_product = a_ext * b_ext;

   // NOTE: only the valid bits need reset; payload registers are qualified by them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_v <= '0;
         hold_v  <= 1'b0;
      end else if (stop) begin
         stage_v <= '0;
         hold_v  <= 1'b0;
      end else if (!stall) begin
         stage_v <= {stage_v[LAT-2:0], s0_v};
         hold_v  <= 1'b0;
      end else if (valid_issue && !hold_v) begin
         hold_v  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         stage_q[0].tag_prf <= s0_op.tag_prf;
         stage_q[0].tag_rob <= s0_op.tag_rob;
`ifdef MUL_EXU_MULH_EN
         stage_q[0].hi      <= s0_op.hi;
`endif
         stage_q[0].product <= s0_product;
         for (int i = 1; i < LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
      if (valid_issue && !hold_v && stall) begin
         hold_q <= issue_op;
      end
   end

   assign valid_Result_mul = stage_v[LAT-1] & wb_ready;

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      tag_PRF_mul = '0;
      tag_ROB_mul = '0;
      result_mul  = '0;
      if (valid_Result_mul) begin
         tag_PRF_mul = stage_q[LAT-1].tag_prf;
         tag_ROB_mul = stage_q[LAT-1].tag_rob;
`ifdef MUL_EXU_MULH_EN
         result_mul  = stage_q[LAT-1].hi ? stage_q[LAT-1].product[PROD_W-1:DATA_W]
                                         : stage_q[LAT-1].product[DATA_W-1:0];
`else
         result_mul  = stage_q[LAT-1].product[DATA_W-1:0];
`endif
      end
   end

`ifndef MUL_EXU_MULH_EN
   logic unused_op_hi;
   logic unused_prod_hi;
   assign unused_op_hi   = op_hi;
   assign unused_prod_hi = ^stage_q[LAT-1].product[PROD_W-1:DATA_W];
`endif

   // The RS must honour freeze_back; an issue while hold is full is lost.
   a_no_issue_into_full_hold : assert property (
      @(posedge clk) disable iff (!rst || stop) !(valid_issue && hold_v));

endmodule
